layer_scheduler: RTL and testbench
==================================

// Module: layer_scheduler
// PURPOSE
//  Top-level sequencer for the accelerator compute engine. On a start pulse it walks
//  cfg_layers x cfg_tiles work items, issuing one eng_start per item and waiting for eng_finish.
//  When every item has completed it raises a one-cycle done.
//  Sits between the host/control register block and the engine's state controller.
// PARAMETERS
//  LAYER_W   4    width of layer count/index (max 2^LAYER_W-1 layers)
//  TILE_W    6    width of tile count/index (max 2^TILE_W-1 tiles per layer)
//  WDOG_W    16   watchdog counter width (used only with SCHED_WATCHDOG_EN)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  start        in   1        one-cycle request; sampled only in IDLE
//  abort        in   1        synchronous abort; returns the block to IDLE from any state, no done
//  cfg_layers   in   LAYER_W  layer count, latched on accepted start
//  cfg_tiles    in   TILE_W   tiles per layer, latched on accepted start
//  wdog_limit   in   WDOG_W   max WAIT cycles; latched on start (ignored unless SCHED_WATCHDOG_EN)
//  eng_start    out  1        one-cycle pulse to engine, issued in ISSUE
//  eng_finish   in   1        engine completion pulse
//  layer_idx    out  LAYER_W  current layer; stable from ISSUE until NEXT
//  tile_idx     out  TILE_W   current tile; stable from ISSUE until NEXT
//  busy         out  1        high in every state except IDLE
//  done         out  1        one-cycle pulse in DONE
//  err          out  1        sticky watchdog error; cleared on next accepted start
//  state        out  3        encoded FSM state, for debug
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched config, indices and watchdog counter 0.
//  State encoding: IDLE=0 LOAD=1 ISSUE=2 WAIT=3 NEXT=4 DONE=5 ERR=6 (7 unused; maps to IDLE).
//  IDLE : on start, latch config, clear indices and err, go to LOAD. start in any other state is ignored.
//  LOAD : if the latched layers==0 or tiles==0, go to DONE (no eng_start). Otherwise go to ISSUE.
//  ISSUE: eng_start=1 for exactly this cycle; go to WAIT; clear the watchdog counter.
//  WAIT : on eng_finish, go to NEXT. eng_finish in any other state is ignored.
//         Because WAIT starts the cycle after ISSUE, an eng_finish in the ISSUE cycle is dropped.
//  NEXT : if tile_idx==tiles-1, set tile_idx=0; then, if layer_idx==layers-1, go to DONE,
//         else layer_idx+1 and go to ISSUE. Otherwise tile_idx+1 and go to ISSUE.
//  DONE : done=1 for one cycle, then go to IDLE. Indices hold their final values until the next start.
//  Latency: start@t gives eng_start@t+2. eng_finish@k gives the next eng_start@k+2,
//           or done@k+2 after the last item.
//  abort has priority over every transition, including a same-cycle start or eng_finish.
//         Next state is IDLE; eng_start/done are not asserted that cycle; err is kept.
//  Mid-operation reset: immediate return to reset values; the engine must be reset alongside.
//  Counters never wrap: indices are bounded by the latched counts (no modulo arithmetic).
// CONFIGURATION
//  SCHED_WATCHDOG_EN defined:
//    - In WAIT, the counter increments each cycle.
//    - Reaching wdog_limit (nonzero) moves the FSM to ERR, sets err=1 and leaves busy=1.
//    - ERR holds until abort or reset. wdog_limit==0 disables the check.
//  SCHED_WATCHDOG_EN undefined:
//    - No counter is instantiated, WAIT waits indefinitely, and ERR is unreachable.
//    - err is tied to 0 and wdog_limit is unused.
// STRUCTURE
//  Package accel_sched_pkg holds:
//    - the sched_state_t enum (3-bit encoding above);
//    - the LAYER_W/TILE_W defaults;
//    - the shared SCHED_ST_* debug constants used by status registers.
//  Sub-module sched_item_counter: the nested tile/layer counter, with clear/step inputs and
//  last/idx outputs. All FSM logic stays in layer_scheduler.
// TESTING
//  1. cfg_layers=2 cfg_tiles=3, engine replies 4 cycles after each eng_start
//     -> 6 eng_start pulses, (layer,tile) 0,0..1,2, done once, busy low the cycle after done.
//  2. cfg_layers=0 or cfg_tiles=0, start
//     -> no eng_start; done exactly 2 cycles after start.
//  3. eng_finish pulses while IDLE and during ISSUE, plus start asserted during WAIT
//     -> all ignored; item count unchanged.
//  4. abort in WAIT of item (1,1), with eng_finish in the same cycle
//     -> IDLE next cycle, no done; a new start restarts at (0,0).
//  5. (SCHED_WATCHDOG_EN) wdog_limit=10, engine never finishes
//     -> ERR/err=1 after 10 WAIT cycles; abort -> IDLE with err still 1; next start clears err.
//  6. rst_n low mid-WAIT
//     -> all outputs 0 asynchronously; state=0 before the next clk edge.

Source files
------------

// File: rtl/accel_sched_pkg.sv
// rtl/accel_sched_pkg.sv - shared state encoding, width defaults and debug state codes for the layer scheduler
package accel_sched_pkg;

    localparam int SCHED_LAYER_W = 4;
    localparam int SCHED_TILE_W  = 6;
    localparam int SCHED_WDOG_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } sched_state_t;

    // Status-register view of the state output
    localparam logic [2:0] SCHED_ST_IDLE  = 3'd0;
    localparam logic [2:0] SCHED_ST_LOAD  = 3'd1;
    localparam logic [2:0] SCHED_ST_ISSUE = 3'd2;
    localparam logic [2:0] SCHED_ST_WAIT  = 3'd3;
    localparam logic [2:0] SCHED_ST_NEXT  = 3'd4;
    localparam logic [2:0] SCHED_ST_DONE  = 3'd5;
    localparam logic [2:0] SCHED_ST_ERR   = 3'd6;

endpackage

// File: rtl/sched_item_counter.sv
// rtl/sched_item_counter.sv - nested tile/layer index counter stepped once per completed work item
module sched_item_counter #(
    parameter int LAYER_W = 4,
    parameter int TILE_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               step,
    input  logic [LAYER_W-1:0] num_layers,
    input  logic [TILE_W-1:0]  num_tiles,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [TILE_W-1:0]  tile_idx,
    output logic               tile_last,
    output logic               layer_last
);

    logic [LAYER_W-1:0] layer_idx_q, layer_idx_d;
    logic [TILE_W-1:0]  tile_idx_q,  tile_idx_d;

    assign tile_last  = (tile_idx_q  == num_tiles  - TILE_W'(1));
    assign layer_last = (layer_idx_q == num_layers - LAYER_W'(1));

    // On the final item the layer index stays put so the last layer remains visible
    always_comb begin
        layer_idx_d = layer_idx_q;
        tile_idx_d  = tile_idx_q;
        if (clear) begin
            layer_idx_d = '0;
            tile_idx_d  = '0;
        end else if (step) begin
            if (tile_last) begin
                tile_idx_d = '0;
                if (!layer_last) begin
                    layer_idx_d = layer_idx_q + LAYER_W'(1);
                end
            end else begin
                tile_idx_d = tile_idx_q + TILE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_idx_q <= '0;
            tile_idx_q  <= '0;
        end else begin
            layer_idx_q <= layer_idx_d;
            tile_idx_q  <= tile_idx_d;
        end
    end

    assign layer_idx = layer_idx_q;
    assign tile_idx  = tile_idx_q;

endmodule

// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - layer x tile work-item sequencer for the compute engine
// Optional WAIT-state watchdog enabled by defining SCHED_WATCHDOG_EN.
module layer_scheduler
    import accel_sched_pkg::*;
#(
    parameter int LAYER_W = SCHED_LAYER_W,
    parameter int TILE_W  = SCHED_TILE_W,
    parameter int WDOG_W  = SCHED_WDOG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [LAYER_W-1:0] cfg_layers,
    input  logic [TILE_W-1:0]  cfg_tiles,
    input  logic [WDOG_W-1:0]  wdog_limit,
    output logic               eng_start,
    input  logic               eng_finish,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [TILE_W-1:0]  tile_idx,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         state
);

    sched_state_t       state_q, state_d;
    logic [LAYER_W-1:0] layers_q, layers_d;
    logic [TILE_W-1:0]  tiles_q, tiles_d;
    logic               eng_start_q, eng_start_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               cnt_clear, cnt_step;
    logic               tile_last, layer_last;

`ifdef SCHED_WATCHDOG_EN
    logic [WDOG_W-1:0]  wdog_cnt_q, wdog_cnt_d;
    logic [WDOG_W-1:0]  wdog_limit_q, wdog_limit_d;
    logic               err_q, err_d;
    logic               wdog_hit;

    assign wdog_hit = (wdog_limit_q != '0) && ((wdog_cnt_q + WDOG_W'(1)) == wdog_limit_q);
    assign err      = err_q;
`else
    logic unused_wdog_limit;

    assign unused_wdog_limit = ^wdog_limit;
    assign err               = 1'b0;
`endif

    sched_item_counter #(
        .LAYER_W (LAYER_W),
        .TILE_W  (TILE_W)
    ) u_item_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .step       (cnt_step),
        .num_layers (layers_q),
        .num_tiles  (tiles_q),
        .layer_idx  (layer_idx),
        .tile_idx   (tile_idx),
        .tile_last  (tile_last),
        .layer_last (layer_last)
    );

    always_comb begin
        state_d   = state_q;
        layers_d  = layers_q;
        tiles_d   = tiles_q;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
`ifdef SCHED_WATCHDOG_EN
        wdog_limit_d = wdog_limit_q;
        err_d        = err_q;
        wdog_cnt_d   = wdog_cnt_q;
        if (state_q == ST_ISSUE) begin
            wdog_cnt_d = '0;
        end else if (state_q == ST_WAIT && wdog_cnt_q != '1) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    layers_d  = cfg_layers;
                    tiles_d   = cfg_tiles;
                    cnt_clear = 1'b1;
                    state_d   = ST_LOAD;
`ifdef SCHED_WATCHDOG_EN
                    wdog_limit_d = wdog_limit;
                    err_d        = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (layers_q == '0 || tiles_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (eng_finish) begin
                    state_d = ST_NEXT;
                end
`ifdef SCHED_WATCHDOG_EN
                else if (wdog_hit) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
`endif
            end
            ST_NEXT: begin
                cnt_step = 1'b1;
                state_d  = (tile_last && layer_last) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything decided above except the sticky error
        if (abort) begin
            state_d   = ST_IDLE;
            layers_d  = layers_q;
            tiles_d   = tiles_q;
            cnt_clear = 1'b0;
            cnt_step  = 1'b0;
`ifdef SCHED_WATCHDOG_EN
            wdog_limit_d = wdog_limit_q;
            err_d        = err_q;
`endif
        end

        eng_start_d = (state_d == ST_ISSUE);
        done_d      = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            layers_q    <= '0;
            tiles_q     <= '0;
            eng_start_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
            wdog_cnt_q   <= '0;
            wdog_limit_q <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            layers_q    <= layers_d;
            tiles_q     <= tiles_d;
            eng_start_q <= eng_start_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef SCHED_WATCHDOG_EN
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_limit_q <= wdog_limit_d;
            err_q        <= err_d;
`endif
        end
    end

    assign eng_start = eng_start_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign state     = state_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - self-checking bench for layer_scheduler with randomized jobs and a work-list model
module tb_layer_scheduler;

    localparam int LW = 4;
    localparam int TW = 6;
    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          eng_finish = 1'b0;
    logic [LW-1:0] cfg_layers = '0;
    logic [TW-1:0] cfg_tiles = '0;
    logic [WW-1:0] wdog_limit = '0;
    logic          eng_start;
    logic [LW-1:0] layer_idx;
    logic [TW-1:0] tile_idx;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    state;

    int n_cmp = 0;
    int n_bad = 0;

    layer_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_layers (cfg_layers),
        .cfg_tiles  (cfg_tiles),
        .wdog_limit (wdog_limit),
        .eng_start  (eng_start),
        .eng_finish (eng_finish),
        .layer_idx  (layer_idx),
        .tile_idx   (tile_idx),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one job; the model is the flat list of (layer,tile) items in layer-major order.
    // abort_item >= 0 aborts in the first WAIT cycle of that item, with a same-cycle eng_finish.
    task automatic run_job(input int nl, input int nt, input bit noise, input int abort_item);
        int items_l[$];
        int items_t[$];
        int k;
        int d;
        for (int l = 0; l < nl; l++)
            for (int t = 0; t < nt; t++) begin
                items_l.push_back(l);
                items_t.push_back(t);
            end
        cfg_layers = LW'(nl);
        cfg_tiles  = TW'(nt);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_layers = LW'($urandom);
        cfg_tiles  = TW'($urandom);
        chk("load_busy", 32'(busy), 1);
        chk("load_no_start", 32'(eng_start), 0);
        chk("err_clear", 32'(err), 0);
        tick();
        k = 0;
        while (k < items_l.size()) begin
            chk("issue_pulse", 32'(eng_start), 1);
            chk("issue_layer", 32'(layer_idx), 32'(items_l[k]));
            chk("issue_tile", 32'(tile_idx), 32'(items_t[k]));
            if (noise) eng_finish = 1'b1;
            tick();
            eng_finish = 1'b0;
            if (k == abort_item) begin
                abort = 1'b1;
                eng_finish = 1'b1;
                tick();
                abort = 1'b0;
                eng_finish = 1'b0;
                chk("abort_state", 32'(state), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(done), 0);
                tick();
                chk("abort_no_done", 32'(done), 0);
                chk("abort_no_start", 32'(eng_start), 0);
                return;
            end
            d = $urandom_range(0, 5);
            for (int c = 0; c < d; c++) begin
                chk("wait_no_start", 32'(eng_start), 0);
                chk("wait_state", 32'(state), 3);
                if (noise && c == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
            eng_finish = 1'b1;
            tick();
            eng_finish = 1'b0;
            chk("next_state", 32'(state), 4);
            tick();
            k++;
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_no_start", 32'(eng_start), 0);
        chk("done_busy", 32'(busy), 1);
        if (nl > 0 && nt > 0) begin
            chk("final_layer", 32'(layer_idx), 32'(nl - 1));
            chk("final_tile", 32'(tile_idx), 0);
        end
        tick();
        chk("after_done", 32'(done), 0);
        chk("after_busy", 32'(busy), 0);
        chk("after_state", 32'(state), 0);
    endtask

    initial begin
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_idx", {layer_idx, tile_idx}, 0);
        rst_n = 1'b1;
        tick();

        for (int c = 0; c < 3; c++) begin
            eng_finish = 1'b1;
            tick();
            eng_finish = 1'b0;
            chk("idle_finish_ignored", 32'(state), 0);
        end

        run_job(2, 3, 1'b0, -1);
        run_job(0, 3, 1'b0, -1);
        run_job(2, 0, 1'b0, -1);
        run_job(2, 3, 1'b1, -1);
        run_job(2, 3, 1'b0, 4);
        run_job(2, 3, 1'b0, -1);
        for (int j = 0; j < 8; j++)
            run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), 1'($urandom), -1);
        run_job(1, 1, 1'b1, -1);

`ifdef SCHED_WATCHDOG_EN
        wdog_limit = 16'd10;
        cfg_layers = 4'd1;
        cfg_tiles  = 6'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("wd_issue", 32'(eng_start), 1);
        tick();
        for (int c = 0; c < 9; c++) tick();
        chk("wd_still_wait", 32'(state), 3);
        tick();
        chk("wd_err_state", 32'(state), 6);
        chk("wd_err", 32'(err), 1);
        chk("wd_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wd_abort_state", 32'(state), 0);
        chk("wd_err_kept", 32'(err), 1);
        wdog_limit = '0;
        run_job(1, 2, 1'b0, -1);
`endif

        cfg_layers = 4'd2;
        cfg_tiles  = 6'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_reset_wait", 32'(state), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_outs", {eng_start, done, err}, 0);
        chk("async_rst_idx", {layer_idx, tile_idx}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_job(1, 2, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
